// File: rtl/wb_trace_collector.sv
// Write-trace collector: buffers GRF writes and DM stores from a pipelined core
// in a small FIFO and drains them in program order over a valid/ready port.
module wb_trace_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grf_we,
  input  logic [31:0]      grf_pc,
  input  logic [4:0]       grf_addr,
  input  logic [31:0]      grf_wdata,
  input  logic             dm_we,
  input  logic [31:0]      dm_pc,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_type,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          type_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] dm_slot;
  logic [CW-1:0] count;
  logic [CW-1:0] space;
  logic          grf_ev;
  logic          dm_ev;
  logic          push_grf;
  logic          push_dm;
  logic          pop;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic [CNT_W:0] drop_sum;

  // Space is judged on start-of-cycle occupancy; a same-cycle pop frees nothing.
  always_comb begin
    grf_ev   = grf_we && (grf_addr != 5'd0);
    dm_ev    = dm_we;
    space    = FULL - count;
    push_grf = grf_ev && (space != '0);
    if (grf_ev) push_dm = dm_ev && (space >= CW'(2));
    else        push_dm = dm_ev && (space != '0);
    n_push   = {1'b0, push_grf} + {1'b0, push_dm};
    n_drop   = {1'b0, grf_ev & ~push_grf} + {1'b0, dm_ev & ~push_dm};
    pop      = out_valid && out_ready;
    dm_slot  = push_grf ? wr_ptr + 1'b1 : wr_ptr;
    drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(n_drop);
  end

  assign out_valid = (count != '0);
  assign out_type  = type_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];
  assign out_addr  = addr_mem[rd_ptr];
  assign out_data  = data_mem[rd_ptr];

  // The GRF record (older, W stage) always takes the first free slot.
  always_ff @(posedge clk) begin
    if (push_grf) begin
      type_mem[wr_ptr] <= 1'b0;
      pc_mem[wr_ptr]   <= grf_pc;
      addr_mem[wr_ptr] <= {27'd0, grf_addr};
      data_mem[wr_ptr] <= grf_wdata;
    end
    if (push_dm) begin
      type_mem[dm_slot] <= 1'b1;
      pc_mem[dm_slot]   <= dm_pc;
      addr_mem[dm_slot] <= dm_addr;
      data_mem[dm_slot] <= dm_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(n_push) - CW'(pop);
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_collector.sv
// Bench for wb_trace_collector: directed test-plan scenarios plus randomized
// traffic, checked every cycle against a queue-based model of the FIFO.
module tb_wb_trace_collector;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             grf_we = 1'b0;
  logic [31:0]      grf_pc = '0;
  logic [4:0]       grf_addr = '0;
  logic [31:0]      grf_wdata = '0;
  logic             dm_we = 1'b0;
  logic [31:0]      dm_pc = '0;
  logic [31:0]      dm_addr = '0;
  logic [31:0]      dm_wdata = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_type;
  logic [31:0]      out_pc;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  wb_trace_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        t;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  rec_t mq[$];
  bit   m_ovf;
  int   m_drops;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: space is what was free before the edge; pops come off the front.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf   = 0;
      m_drops = 0;
    end else begin
      int  sp;
      int  nd;
      bit  g;
      bit  d;
      rec_t gr;
      rec_t dr;
      sp = DEPTH - mq.size();
      g  = grf_we && (grf_addr != 0);
      d  = dm_we;
      nd = 0;
      gr = '{1'b0, grf_pc, {27'd0, grf_addr}, grf_wdata};
      dr = '{1'b1, dm_pc, dm_addr, dm_wdata};
      if (out_ready && mq.size() != 0) void'(mq.pop_front());
      if (g) begin
        if (sp >= 1) begin mq.push_back(gr); sp--; end
        else nd++;
      end
      if (d) begin
        if (sp >= 1) mq.push_back(dr);
        else nd++;
      end
      if (nd != 0) begin
        m_ovf   = 1;
        m_drops = (m_drops + nd > SAT) ? SAT : m_drops + nd;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk(out_valid == (mq.size() != 0), "cmp_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0 && out_valid) begin
        chk(out_type == mq[0].t,    "cmp_type", 32'(out_type), 32'(mq[0].t));
        chk(out_pc   == mq[0].pc,   "cmp_pc",   out_pc,   mq[0].pc);
        chk(out_addr == mq[0].addr, "cmp_addr", out_addr, mq[0].addr);
        chk(out_data == mq[0].data, "cmp_data", out_data, mq[0].data);
      end
      chk(overflow == m_ovf, "cmp_overflow", 32'(overflow), 32'(m_ovf));
      chk(int'(drop_cnt) == m_drops, "cmp_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    grf_we = 1'b0;
    dm_we  = 1'b0;
  endtask

  task automatic set_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] v);
    grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wdata = v;
  endtask

  task automatic set_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] v);
    dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wdata = v;
  endtask

  initial begin
    int n;
    #1;
    chk(out_valid == 1'b0, "rst_valid", 32'(out_valid), 32'd0);
    chk(overflow == 1'b0, "rst_overflow", 32'(overflow), 32'd0);
    chk(drop_cnt == '0, "rst_drop_cnt", 32'(drop_cnt), 32'd0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // Single GRF write
    out_ready = 1'b1;
    set_grf(32'h3000, 5'd5, 32'h1234);
    cyc();
    idle();
    chk(out_valid == 1'b1, "single_valid", 32'(out_valid), 32'd1);
    chk(out_type == 1'b0, "single_type", 32'(out_type), 32'd0);
    chk(out_pc == 32'h3000, "single_pc", out_pc, 32'h3000);
    chk(out_addr == 32'd5, "single_addr", out_addr, 32'd5);
    chk(out_data == 32'h1234, "single_data", out_data, 32'h1234);
    cyc();
    chk(out_valid == 1'b0, "single_drained", 32'(out_valid), 32'd0);

    // $0 writes are not events
    set_grf(32'h3004, 5'd0, 32'hdead);
    repeat (10) cyc();
    idle();
    chk(out_valid == 1'b0, "r0_valid", 32'(out_valid), 32'd0);
    chk(overflow == 1'b0, "r0_overflow", 32'(overflow), 32'd0);
    chk(drop_cnt == '0, "r0_drop_cnt", 32'(drop_cnt), 32'd0);

    // Dual event: GRF first, DM second
    set_grf(32'h3008, 5'd8, 32'd7);
    set_dm(32'h300c, 32'h10, 32'd9);
    cyc();
    idle();
    chk(out_type == 1'b0, "dual_first_type", 32'(out_type), 32'd0);
    chk(out_pc == 32'h3008, "dual_first_pc", out_pc, 32'h3008);
    cyc();
    chk(out_type == 1'b1, "dual_second_type", 32'(out_type), 32'd1);
    chk(out_pc == 32'h300c, "dual_second_pc", out_pc, 32'h300c);
    chk(out_addr == 32'h10, "dual_second_addr", out_addr, 32'h10);
    cyc();
    chk(out_valid == 1'b0, "dual_drained", 32'(out_valid), 32'd0);

    // Fill and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_grf(32'h4000 + 32'(8 * i), 5'(i + 1), 32'(i));
      set_dm(32'h4004 + 32'(8 * i), 32'h100 + 32'(i), 32'h50 + 32'(i));
      cyc();
    end
    idle();
    chk(drop_cnt == 4'd2, "fill_drop_cnt", 32'(drop_cnt), 32'd2);
    chk(overflow == 1'b1, "fill_overflow", 32'(overflow), 32'd1);
    chk(out_pc == 32'h4000, "fill_head_pc", out_pc, 32'h4000);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    set_grf(32'h5000, 5'd20, 32'haa);
    set_dm(32'h5004, 32'h200, 32'hbb);
    cyc();
    idle();
    chk(drop_cnt == 4'd3, "seven_dual_drop_cnt", 32'(drop_cnt), 32'd3);

    // Full, pop and push together: push still dropped
    out_ready = 1'b1;
    set_grf(32'h6000, 5'd21, 32'hcc);
    cyc();
    idle();
    chk(drop_cnt == 4'd4, "fullpop_drop_cnt", 32'(drop_cnt), 32'd4);
    chk(out_pc == 32'h4008, "fullpop_head_pc", out_pc, 32'h4008);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) n++;
      cyc();
    end
    chk(n == 7, "fullpop_drain_len", 32'(n), 32'd7);

    // Async reset mid-drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_grf(32'h7000 + 32'(4 * i), 5'(i + 1), 32'(i));
      cyc();
    end
    idle();
    chk(out_valid == 1'b1, "prereset_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk(out_valid == 1'b0, "async_valid", 32'(out_valid), 32'd0);
    chk(overflow == 1'b0, "async_overflow", 32'(overflow), 32'd0);
    chk(drop_cnt == '0, "async_drop_cnt", 32'(drop_cnt), 32'd0);
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    cyc(); cyc();
    chk(out_valid == 1'b0, "postreset_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with varying consumer pressure
    for (int i = 0; i < 3000; i++) begin
      int rp;
      rp = ((i / 300) % 3 == 0) ? 90 : (((i / 300) % 3 == 1) ? 50 : 10);
      out_ready = ($urandom_range(0, 99) < rp);
      grf_we    = ($urandom_range(0, 99) < 60);
      grf_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      grf_pc    = $urandom;
      grf_wdata = $urandom;
      dm_we     = ($urandom_range(0, 99) < 40);
      dm_pc     = $urandom;
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
      end
      cyc();
    end
    idle();
    out_ready = 1'b1;
    repeat (DEPTH + 2) cyc();
    chk(out_valid == 1'b0, "final_drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
